// File: rtl/bram_fifo.sv
// Synchronous FIFO on an inferred simple-dual-port BRAM with registered output.
// Optional BRAM_FIFO_BYPASS_EN: empty-FIFO push loads rd_data directly.
module bram_fifo #(
   parameter int DW       = 9,
   parameter int AW       = 4,
   parameter int AF_LEVEL = 12
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          flush,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [DW-1:0] wr_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic [AW:0]   peak,
   output logic          ena,
   output logic          enb
);

   localparam int          DEPTH = 1 << AW;
   localparam logic [AW:0] CAP   = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF    = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] ONE   = (AW+1)'(1);

   typedef enum logic [1:0] {
      EMPTY,
      FETCH,
      VALID
   } state_t;

   state_t state, state_nxt;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   mcount, mcount_nxt;
   logic [AW:0]   count_nxt, peak_nxt;
   logic          push, pop, mem_ne, byp;

   assign full        = (count == CAP);
   assign empty       = (count == '0);
   assign almost_full = (count >= AF);
   assign wr_ready    = !full;
   assign rd_valid    = (state == VALID);

   assign push   = wr_valid && wr_ready;
   assign pop    = rd_valid && rd_ready;
   assign mem_ne = (mcount != '0);

`ifdef BRAM_FIFO_BYPASS_EN
   assign byp = push && (state == EMPTY) && !mem_ne;
`else
   assign byp = 1'b0;
`endif

   assign ena = push && !byp;
   assign enb = ((state == EMPTY) || pop) && mem_ne;

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: begin
            if (byp)
               state_nxt = VALID;
            else if (mem_ne)
               state_nxt = FETCH;
         end
         FETCH: state_nxt = VALID;
         VALID: begin
            if (pop && !mem_ne)
               state_nxt = EMPTY;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + ONE;
      else if (pop && !push)
         count_nxt = count - ONE;
   end

   // Memory occupancy excludes the word sitting in the output register.
   always_comb begin
      mcount_nxt = mcount;
      if (ena && !enb)
         mcount_nxt = mcount + ONE;
      else if (enb && !ena)
         mcount_nxt = mcount - ONE;
   end

   assign peak_nxt = (count_nxt > peak) ? count_nxt : peak;

   always_ff @(posedge CLK) begin
      if (!RSTN || flush) begin
         state  <= EMPTY;
         wptr   <= '0;
         rptr   <= '0;
         mcount <= '0;
         count  <= '0;
         peak   <= '0;
      end else begin
         state  <= state_nxt;
         mcount <= mcount_nxt;
         count  <= count_nxt;
         peak   <= peak_nxt;
         if (ena)
            wptr <= wptr + 1'b1;
         if (enb)
            rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTN)
         rd_data <= '0;
      else if (!flush) begin
         if (byp)
            rd_data <= wr_data;
         else if (enb)
            rd_data <= mem[rptr];
      end
   end

   always_ff @(posedge CLK) begin
      if (ena && RSTN && !flush)
         mem[wptr] <= wr_data;
   end

endmodule
